// File: rtl/bnn_test_sequencer.sv
// bnn_test_sequencer
// Self-checking test driver for a BNN classifier core. Walks a testcase ROM,
// presents each feature vector over a valid/ready handshake, waits (bounded)
// for the prediction and scores it against the label stored with the vector.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle pulse, begins a run when idle
//   rom_addr      testcase ROM address (synchronous ROM, data one cycle later)
//   rom_data      {label, features} ROM word
//   features      feature vector to the classifier
//   feat_valid    features valid; feat_ready is the classifier's accept
//   prediction    classifier result, sampled while pred_valid is high
//   busy / done   run in progress / run complete (done held until next start)
//   tested_cnt, correct_cnt, timeout_cnt   run statistics
module bnn_test_sequencer #(
    parameter int FEAT_CNT  = 128,
    parameter int FEAT_BITS = 4,
    parameter int CLASS_CNT = 6,
    parameter int TEST_CNT  = 1000,
    parameter int TIMEOUT   = 1024,
    localparam int FW = FEAT_CNT * FEAT_BITS,
    localparam int LW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1,
    localparam int AW = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1,
    localparam int CW = $clog2(TEST_CNT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [AW-1:0]   rom_addr,
    input  logic [FW+LW-1:0] rom_data,
    output logic [FW-1:0]   features,
    output logic            feat_valid,
    input  logic            feat_ready,
    input  logic [LW-1:0]   prediction,
    input  logic            pred_valid,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   tested_cnt,
    output logic [CW-1:0]   correct_cnt,
    output logic [CW-1:0]   timeout_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_SCORE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]    state;
    logic [AW-1:0] index;
    logic [LW-1:0] label;
    logic [LW-1:0] pred;
    logic [TW-1:0] tcnt;
    logic          timed_out;

    // The ROM is synchronous, so presenting the index continuously means the
    // word addressed during FETCH is on rom_data when LOAD samples it.
    assign rom_addr = index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            index       <= '0;
            label       <= '0;
            pred        <= '0;
            tcnt        <= '0;
            timed_out   <= 1'b0;
            features    <= '0;
            feat_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tested_cnt  <= '0;
            correct_cnt <= '0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tested_cnt  <= '0;
                        correct_cnt <= '0;
                        timeout_cnt <= '0;
                        done        <= 1'b0;
                        index       <= '0;
                        busy        <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    features   <= rom_data[FW-1:0];
                    label      <= rom_data[FW +: LW];
                    feat_valid <= 1'b1;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    // features is only rewritten in LOAD, so it stays stable
                    // for as long as the classifier stalls here.
                    if (feat_ready) begin
                        feat_valid <= 1'b0;
                        tcnt       <= '0;
                        timed_out  <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // pred_valid is only looked at here, so a stale or early
                    // prediction during the handshake cycle is never scored.
                    if (pred_valid) begin
                        pred  <= prediction;
                        state <= S_SCORE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timed_out <= 1'b1;
                        state     <= S_SCORE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_SCORE: begin
                    tested_cnt <= tested_cnt + 1'b1;
                    if (timed_out)
                        timeout_cnt <= timeout_cnt + 1'b1;
                    else if (pred == label)
                        correct_cnt <= correct_cnt + 1'b1;
                    if (index == AW'(TEST_CNT - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_test_sequencer.sv
// Bench for bnn_test_sequencer: a ROM of 8 cases, a behavioural classifier
// whose prediction is derived from the presented vector, and a negedge
// compare process tracking which case must be on the feature bus.
module tb_bnn_test_sequencer;
    localparam int FEAT_CNT = 8, FEAT_BITS = 4, CLASS_CNT = 6;
    localparam int TEST_CNT = 8, TIMEOUT = 16;
    localparam int FW = FEAT_CNT * FEAT_BITS, LW = 3, AW = 3, CW = 4;

    logic clk = 1'b0;
    logic rst, start;
    logic [AW-1:0]    rom_addr;
    logic [FW+LW-1:0] rom_data;
    logic [FW-1:0]    features;
    logic             feat_valid, feat_ready, pred_valid, busy, done;
    logic [LW-1:0]    prediction;
    logic [CW-1:0]    tested_cnt, correct_cnt, timeout_cnt;

    bnn_test_sequencer #(.FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .CLASS_CNT(CLASS_CNT),
                         .TEST_CNT(TEST_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .features(features), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .prediction(prediction), .pred_valid(pred_valid), .busy(busy), .done(done),
        .tested_cnt(tested_cnt), .correct_cnt(correct_cnt), .timeout_cnt(timeout_cnt));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [FW-1:0] rom_feat [TEST_CNT];
    logic [LW-1:0] rom_lbl  [TEST_CNT];

    int mode = 0;          // 0: correct label, 1: always 0, 2: out-of-range 7
    bit stall_en = 1'b0;   // hold feat_ready low 7 cycles on case 3
    bit drop_en  = 1'b0;   // never raise pred_valid on case 2
    int stall_rem = 0;
    int m_case = 0;
    int cidx;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] pred_for(input int m, input int i);
        if (m == 0) return rom_lbl[i];
        if (m == 1) return '0;
        return 3'd7;
    endfunction

    // Expected totals from the scoring rules, independent of timing.
    task automatic model_counts(output int corr, output int tout);
        corr = 0; tout = 0;
        for (int i = 0; i < TEST_CNT; i++) begin
            if (drop_en && i == 2) tout++;
            else if (pred_for(mode, i) == rom_lbl[i]) corr++;
        end
    endtask

    always @(posedge clk) rom_data <= {rom_lbl[rom_addr], rom_feat[rom_addr]};

    // Behavioural classifier: the case number sits in the low feature nibble.
    always_comb begin
        cidx       = int'(features[3:0]);
        prediction = pred_for(mode, cidx);
        pred_valid = !(drop_en && cidx == 2);
        feat_ready = !(stall_en && feat_valid && cidx == 3 && stall_rem > 0);
    end

    always @(posedge clk) begin
        if (start && !busy) stall_rem <= 7;
        else if (feat_valid && !feat_ready) stall_rem <= stall_rem - 1;
    end

    // Compare process: whenever feat_valid is high the bus must carry the ROM
    // vector of the next case due for a handshake.
    always @(negedge clk) begin
        if (rst) begin
            m_case = 0;
        end else begin
            if (start && !busy) m_case = 0;
            if (feat_valid) begin
                if (m_case < TEST_CNT) chk("features_bus", features, rom_feat[m_case]);
                else chk("extra_vector", m_case, TEST_CNT - 1);
            end
            if (busy) chk("tested_le_sent", longint'(tested_cnt <= m_case), 1);
            if (feat_valid && feat_ready) m_case++;
        end
    end

    task automatic run_test(input string name, input int md, input bit st, input bit dr,
                            input bit mid, input int exp_cyc, input int exp_corr, input int exp_to);
        int c, mc, mt;
        mode = md; stall_en = st; drop_en = dr;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        chk({name, "_busy_start"}, busy, 1);
        chk({name, "_done_clr"}, done, 0);
        chk({name, "_tested_clr"}, tested_cnt, 0);
        chk({name, "_correct_clr"}, correct_cnt, 0);
        c = 0;
        while (!done && c < 2000) begin
            @(posedge clk); #2;
            c++;
            start = mid && (c == 10);
        end
        start = 1'b0;
        model_counts(mc, mt);
        chk({name, "_cycles"}, c, exp_cyc);
        chk({name, "_tested"}, tested_cnt, TEST_CNT);
        chk({name, "_correct"}, correct_cnt, exp_corr);
        chk({name, "_correct_model"}, correct_cnt, mc);
        chk({name, "_timeout"}, timeout_cnt, exp_to);
        chk({name, "_timeout_model"}, timeout_cnt, mt);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_feat_held"}, features, rom_feat[TEST_CNT-1]);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_fvalid"}, feat_valid, 0);
        chk({name, "_features"}, features, 0);
        chk({name, "_addr"}, rom_addr, 0);
        chk({name, "_tested"}, tested_cnt, 0);
        chk({name, "_correct"}, correct_cnt, 0);
        chk({name, "_timeout"}, timeout_cnt, 0);
    endtask

    initial begin
        int c;
        bit seen;
        for (int i = 0; i < TEST_CNT; i++) begin
            rom_feat[i] = 32'h5A3C_1E70 + 32'(i) * 32'h0123_4571;
            rom_lbl[i]  = LW'(i % CLASS_CNT);
        end
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #2 chk_reset("reset");
        rst = 1'b0;

        run_test("comb",    0, 0, 0, 0, 40, 8, 0);
        run_test("zero",    1, 0, 0, 0, 40, 2, 0);
        run_test("stall",   0, 1, 0, 0, 47, 8, 0);
        run_test("tmo",     0, 0, 1, 0, 55, 7, 1);
        run_test("badpred", 2, 0, 0, 0, 40, 0, 0);

        // Abort during WAIT of case 5.
        mode = 0; stall_en = 0; drop_en = 0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        c = 0; seen = 0;
        while (!seen && c < 200) begin
            @(negedge clk);
            c++;
            seen = feat_valid && feat_ready && features[3:0] == 4'd5;
        end
        chk("reach_case5", seen, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1 chk_reset("midrst");
        @(posedge clk); #2 rst = 1'b0;

        run_test("after_rst", 0, 0, 0, 0, 40, 8, 0);
        run_test("midstart",  0, 0, 0, 1, 40, 8, 0);
        run_test("rerun",     1, 0, 0, 0, 40, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
